// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with per-register valid bits and a clear sweep.
// Read latency is 0 (combinational) or 1 cycle (READ_LAT); writes land on the rising edge.
// No backpressure: writes arriving while the clear sweep runs are dropped and flagged on wr_drop.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   write/writenum/data_in write port (accepted only when not busy)
//   readnum_a/readnum_b    read addresses; data_out_x/valid_x are the matching outputs
//   clear                  pulse that starts zeroing all registers, one per cycle
//   busy                   high while the clear sweep is running
//   wr_drop                high in any cycle where a write is discarded because of busy
module regfile_2r1w #(
  parameter int WIDTH    = 16,
  parameter int AW       = 3,
  parameter int READ_LAT = 0,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             busy,
  output logic             wr_drop
);

  localparam int NREGS = 2 ** AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];
  logic [NREGS-1:0] vld_q, vld_d;

  logic             wr_en;
  logic [WIDTH-1:0] rd_a_dat, rd_b_dat;
  logic             rd_a_vld, rd_b_vld;

  assign busy    = (state_q == CLEAR);
  assign wr_en   = write & ~busy;
  assign wr_drop = write & busy;

  // Next-state: writes only in IDLE; a coincident clear still takes the
  // write this edge and starts sweeping on the following cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          mem_d[writenum] = data_in;
          vld_d[writenum] = 1'b1;
        end
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[idx_q] = '0;
        vld_d[idx_q] = 1'b0;
        // Index wraps back to 0 after the last register, leaving it ready.
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read path: stored contents, overridden by the in-flight write when
  // forwarding is enabled. wr_en is already false during the sweep, so
  // reads while busy always see the partially cleared array.
  always_comb begin
    rd_a_dat = mem_q[readnum_a];
    rd_a_vld = vld_q[readnum_a];
    rd_b_dat = mem_q[readnum_b];
    rd_b_vld = vld_q[readnum_b];
    if (BYPASS != 0 && wr_en && (writenum == readnum_a)) begin
      rd_a_dat = data_in;
      rd_a_vld = 1'b1;
    end
    if (BYPASS != 0 && wr_en && (writenum == readnum_b)) begin
      rd_b_dat = data_in;
      rd_b_vld = 1'b1;
    end
  end

  generate
    if (READ_LAT == 1) begin : g_rd_reg
      logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
      logic             va_q, va_d, vb_q, vb_d;

      always_comb begin
        out_a_d = rd_a_dat;
        out_b_d = rd_b_dat;
        va_d    = rd_a_vld;
        vb_d    = rd_b_vld;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_a_q <= '0;
          out_b_q <= '0;
          va_q    <= 1'b0;
          vb_q    <= 1'b0;
        end else begin
          out_a_q <= out_a_d;
          out_b_q <= out_b_d;
          va_q    <= va_d;
          vb_q    <= vb_d;
        end
      end

      assign data_out_a = out_a_q;
      assign data_out_b = out_b_q;
      assign valid_a    = va_q;
      assign valid_b    = vb_q;
    end else begin : g_rd_comb
      assign data_out_a = rd_a_dat;
      assign data_out_b = rd_b_dat;
      assign valid_a    = rd_a_vld;
      assign valid_b    = rd_b_vld;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic [2:0]  ra, rb;
  logic        clear;

  // Default instance (READ_LAT=0, BYPASS=1)
  logic [15:0] d_a, d_b;
  logic        d_va, d_vb, d_busy, d_drop;
  // No-forwarding instance
  logic [15:0] n_a, n_b;
  logic        n_va, n_vb, n_busy, n_drop;
  // Registered-read instance
  logic [15:0] l_a, l_b;
  logic        l_va, l_vb, l_busy, l_drop;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_2r1w u_dut (
    .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum_a(ra), .readnum_b(rb), .clear(clear),
    .data_out_a(d_a), .data_out_b(d_b), .valid_a(d_va), .valid_b(d_vb),
    .busy(d_busy), .wr_drop(d_drop)
  );

  regfile_2r1w #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum_a(ra), .readnum_b(rb), .clear(clear),
    .data_out_a(n_a), .data_out_b(n_b), .valid_a(n_va), .valid_b(n_vb),
    .busy(n_busy), .wr_drop(n_drop)
  );

  regfile_2r1w #(.READ_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
    .readnum_a(ra), .readnum_b(rb), .clear(clear),
    .data_out_a(l_a), .data_out_b(l_b), .valid_a(l_va), .valid_b(l_vb),
    .busy(l_busy), .wr_drop(l_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  wn;
    logic [15:0] din;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eva;
    logic        evb;
    logic [15:0] enb_a;
    logic [15:0] el1_a;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the falling edge; outputs are
  // inspected 1ns later, well before the next rising edge.
  task automatic step(input logic wr, input logic [2:0] wn, input logic [15:0] din,
                      input logic [2:0] a, input logic [2:0] b, input logic clr);
    @(negedge clk);
    write    = wr;
    writenum = wn;
    data_in  = din;
    ra       = a;
    rb       = b;
    clear    = clr;
    #1;
  endtask

  initial begin
    //          wr    wn    din     ra    rb    ea      eb     eva   evb   nb_a   l1_a
    vt[0] = '{1'b0, 3'd0, 16'd0,  3'd1, 3'd3, 16'd0,  16'd0,  1'b0, 1'b0, 16'd0,  16'd0};
    vt[1] = '{1'b1, 3'd1, 16'd1,  3'd1, 3'd3, 16'd1,  16'd0,  1'b1, 1'b0, 16'd0,  16'd0};
    vt[2] = '{1'b1, 3'd3, 16'd3,  3'd1, 3'd3, 16'd1,  16'd3,  1'b1, 1'b1, 16'd1,  16'd1};
    vt[3] = '{1'b0, 3'd0, 16'd0,  3'd1, 3'd3, 16'd1,  16'd3,  1'b1, 1'b1, 16'd1,  16'd1};
    vt[4] = '{1'b0, 3'd0, 16'd0,  3'd5, 3'd5, 16'd0,  16'd0,  1'b0, 1'b0, 16'd0,  16'd1};
    vt[5] = '{1'b1, 3'd4, 16'd4,  3'd4, 3'd1, 16'd4,  16'd1,  1'b1, 1'b1, 16'd0,  16'd0};
    vt[6] = '{1'b0, 3'd4, 16'd64, 3'd4, 3'd4, 16'd4,  16'd4,  1'b1, 1'b1, 16'd4,  16'd4};
    vt[7] = '{1'b1, 3'd4, 16'd17, 3'd4, 3'd3, 16'd17, 16'd3,  1'b1, 1'b1, 16'd4,  16'd4};
    vt[8] = '{1'b0, 3'd0, 16'd0,  3'd4, 3'd4, 16'd17, 16'd17, 1'b1, 1'b1, 16'd17, 16'd17};

    rst_n = 1'b0; write = 1'b0; writenum = '0; data_in = '0;
    ra = '0; rb = '0; clear = 1'b0;
    #1;
    chk("reset busy", 32'(d_busy), 32'd0);
    chk("reset wr_drop", 32'(d_drop), 32'd0);
    chk("reset l1 data_a", 32'(l_a), 32'd0);
    chk("reset l1 valid_a", 32'(l_va), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vt[i].wr, vt[i].wn, vt[i].din, vt[i].ra, vt[i].rb, 1'b0);
      chk($sformatf("vec%0d data_a", i), 32'(d_a), 32'(vt[i].ea));
      chk($sformatf("vec%0d data_b", i), 32'(d_b), 32'(vt[i].eb));
      chk($sformatf("vec%0d valid_a", i), 32'(d_va), 32'(vt[i].eva));
      chk($sformatf("vec%0d valid_b", i), 32'(d_vb), 32'(vt[i].evb));
      chk($sformatf("vec%0d nobypass data_a", i), 32'(n_a), 32'(vt[i].enb_a));
      chk($sformatf("vec%0d lat1 data_a", i), 32'(l_a), 32'(vt[i].el1_a));
    end

    // Registered read: address change shows up one edge later.
    step(1'b1, 3'd2, 16'd2, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'd0, 3'd2, 3'd0, 1'b0);
    chk("lat1 before edge", 32'(l_a), 32'd0);
    chk("lat0 r2", 32'(d_a), 32'd2);
    step(1'b0, 3'd0, 16'd0, 3'd2, 3'd0, 1'b0);
    chk("lat1 after edge", 32'(l_a), 32'd2);

    // Clear sweep over r0..r7 = 1..8.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 16'(i + 1), 3'd0, 3'd0, 1'b0);
    end
    step(1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b1);
    chk("clear pulse busy still low", 32'(d_busy), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      logic        w;
      logic        cl;
      w  = (c == 3);
      cl = (c == 5);
      step(w, 3'(c - 1), 16'd99, 3'(c - 1), (c > 1) ? 3'(c - 2) : 3'd7, cl);
      chk($sformatf("sweep%0d busy", c), 32'(d_busy), 32'd1);
      chk($sformatf("sweep%0d data_a", c), 32'(d_a), 32'(c));
      chk($sformatf("sweep%0d data_b", c), 32'(d_b), (c > 1) ? 32'd0 : 32'd8);
      chk($sformatf("sweep%0d wr_drop", c), 32'(d_drop), 32'(w));
    end
    step(1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b0);
    chk("sweep end busy", 32'(d_busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 16'd0, 3'(i), 3'(i), 1'b0);
      chk($sformatf("post clear r%0d data", i), 32'(d_a), 32'd0);
      chk($sformatf("post clear r%0d valid", i), 32'(d_vb), 32'd0);
    end

    // Clear coinciding with a write, then reset mid-sweep.
    step(1'b1, 3'd3, 16'd5, 3'd3, 3'd0, 1'b1);
    chk("clear+write bypass", 32'(d_a), 32'd5);
    step(1'b0, 3'd0, 16'd0, 3'd3, 3'd0, 1'b0);
    chk("clear+write stored", 32'(d_a), 32'd5);
    chk("clear+write busy", 32'(d_busy), 32'd1);
    step(1'b0, 3'd0, 16'd0, 3'd3, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset mid-sweep busy", 32'(d_busy), 32'd0);
    chk("reset mid-sweep l1 data_a", 32'(l_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      #1;
      chk($sformatf("reset r%0d data", i), 32'(d_a), 32'd0);
      chk($sformatf("reset r%0d valid", i), 32'(d_va), 32'd0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    write    = 1'b1;
    writenum = 3'd2;
    data_in  = 16'd9;
    ra       = 3'd0;
    #1;
    step(1'b0, 3'd0, 16'd0, 3'd2, 3'd2, 1'b0);
    chk("post reset write r2", 32'(d_a), 32'd9);
    chk("post reset valid r2", 32'(d_vb), 32'd1);
    chk("post reset busy", 32'(d_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
